// File: rtl/logic_exec_stage.sv
// logic_exec_stage
//   Registered execute stage for x86 logical ops (AND / OR / NOT / XOR) at
//   byte, word and dword operand size. The result and its x86 flags are computed
//   combinationally from the incoming operands. They are then held in a visible
//   output register (OUT) backed by a one-entry skid register (SKID). The skid
//   register lets in_ready be a pure register output and still sustain one op per
//   cycle.
//
// Ports
//   clk           rising-edge clock
//   reset_n       synchronous reset, active-low
//   flush         synchronous kill of OUT and SKID; a same-cycle input is dropped
//   in_valid      upstream op valid
//   in_ready      stage can accept (registered, = !skid_valid)
//   in_op         00 AND, 01 OR, 10 NOT a, 11 XOR
//   in_size       00 byte, 01 word, 10/11 dword
//   in_a, in_b    operands (in_b ignored for NOT)
//   in_tag        destination-register tag
//   out_valid     result valid
//   out_ready     downstream accepts
//   out_result    result, zero-extended above the operand size
//   out_tag       destination tag
//   out_flags     {OF,SF,ZF,PF,CF}
//   out_flags_we  1 = write EFLAGS (0 for NOT)

module logic_exec_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [1:0]            in_size,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [4:0]            out_flags,
    output logic                  out_flags_we
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic [DATA_WIDTH-1:0] raw;
    logic [DATA_WIDTH-1:0] c_result;
    logic                  c_sf;
    logic                  c_zf;
    logic                  c_pf;
    logic [4:0]            c_flags;
    logic                  c_flags_we;

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_result;
    logic [TAG_WIDTH-1:0]  skid_tag;
    logic [4:0]            skid_flags;
    logic                  skid_flags_we;

    logic                  accept;
    logic                  deliver;

    always_comb begin
        raw = '0;
        case (in_op)
            OP_AND:  raw = in_a & in_b;
            OP_OR:   raw = in_a | in_b;
            OP_NOT:  raw = ~in_a;
            OP_XOR:  raw = in_a ^ in_b;
            default: raw = '0;
        endcase
    end

    // Masking the result before deriving flags guarantees that operand bits above the
    // operand size cannot leak into ZF. Size 11 falls into the dword branch.
    always_comb begin
        c_result = raw;
        c_sf     = raw[DATA_WIDTH-1];
        case (in_size)
            2'b00: begin
                c_result = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
                c_sf     = raw[7];
            end
            2'b01: begin
                c_result = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
                c_sf     = raw[15];
            end
            default: begin
                c_result = raw;
                c_sf     = raw[DATA_WIDTH-1];
            end
        endcase
        c_zf       = (c_result == '0);
        c_pf       = ~^c_result[7:0];
        c_flags    = {1'b0, c_sf, c_zf, c_pf, 1'b0};
        c_flags_we = (in_op != OP_NOT);
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    // Occupancy only ever moves through empty -> OUT -> OUT+SKID and back.
    // SKID is never valid while OUT is empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_tag       <= '0;
            out_flags     <= '0;
            out_flags_we  <= 1'b0;
            skid_valid    <= 1'b0;
            skid_result   <= '0;
            skid_tag      <= '0;
            skid_flags    <= '0;
            skid_flags_we <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (deliver) begin
            if (skid_valid) begin
                out_result   <= skid_result;
                out_tag      <= skid_tag;
                out_flags    <= skid_flags;
                out_flags_we <= skid_flags_we;
                skid_valid   <= 1'b0;
            end else if (accept) begin
                out_result   <= c_result;
                out_tag      <= in_tag;
                out_flags    <= c_flags;
                out_flags_we <= c_flags_we;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (!out_valid) begin
            if (accept) begin
                out_valid    <= 1'b1;
                out_result   <= c_result;
                out_tag      <= in_tag;
                out_flags    <= c_flags;
                out_flags_we <= c_flags_we;
            end
        end else if (accept) begin
            // OUT is stalled: park the new op in SKID, which drops in_ready next cycle.
            skid_valid    <= 1'b1;
            skid_result   <= c_result;
            skid_tag      <= in_tag;
            skid_flags    <= c_flags;
            skid_flags_we <= c_flags_we;
        end
    end

endmodule
